// File: rtl/arb_pkg.sv
// Shared types and the round-robin priority pick for the four-way grant controller.
// The pick is pure combinational logic so both the arbiter and any future user see one definition.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // First set request scanning ptr+1, ptr+2, ptr+3, ptr with natural 2-bit wrap.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] pick;
    logic             found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ptr + IDX_W'(k);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/decoder.sv
// 2-to-4 one-hot decoder with a valid qualifier; output is all-zero when valid is low.
// Purely combinational, so a registered index/valid gives a glitch-free select.
module decoder
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0]   idx,
  input  logic               valid,
  output logic [NUM_REQ-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (valid) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin owner selection for one shared resource among four requesters, one registered cycle
// from request to grant, with an optional hold limit and a mandatory idle cycle between owners.
module rr_grant_ctrl
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               expired
);

  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_q,   state_d;
  logic [IDX_W-1:0] idx_q,     idx_d;
  logic [IDX_W-1:0] ptr_q,     ptr_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             expired_q, expired_d;

  logic             vol_rel;
  logic             frc_rel;
  logic [IDX_W-1:0] pick;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    expired_d = 1'b0;
    pick      = rr_pick(req, ptr_q);
    vol_rel   = !req[idx_q];
    frc_rel   = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);

    case (state_q)
      IDLE: begin
        if (en && (|req)) begin
          state_d = GRANT;
          idx_d   = pick;
          ptr_d   = pick;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (vol_rel || frc_rel) begin
          state_d   = IDLE;
          idx_d     = '0;
          cnt_d     = '0;
          // A coincident voluntary drop takes precedence, so no expiry is flagged.
          expired_d = frc_rel && !vol_rel;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    gnt_valid = (state_q == GRANT);
    gnt_idx   = idx_q;
    expired   = expired_q;
  end

  decoder u_decoder (
    .idx    (idx_q),
    .valid  (gnt_valid),
    .onehot (gnt)
  );

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Bench for rr_grant_ctrl: two instances (hold limits 3 and 4) share stimulus and are compared
// every cycle against an owner/age/last-owner model, plus directed literal expectations.
module tb_rr_grant_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       en;

  logic [3:0] gnt_a, gnt_b;
  logic [1:0] idx_a, idx_b;
  logic       vld_a, vld_b;
  logic       exp_a, exp_b;

  int n_pass  = 0;
  int n_total = 0;

  rr_grant_ctrl #(.MAX_HOLD(3), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst(rst), .req(req), .en(en),
    .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(vld_a), .expired(exp_a)
  );

  rr_grant_ctrl #(.MAX_HOLD(4), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .req(req), .en(en),
    .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(vld_b), .expired(exp_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    n_total++;
    if (act !== req_v) begin
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req_v, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Model: who owns the resource, how many cycles it has held it, who owned last.
  int owner    [2];
  int held     [2];
  int last_own [2];
  bit exp_m    [2];
  int hold_lim [2] = '{3, 4};
  bit model_ok = 1'b0;
  bit vol, frc;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        owner[d]    = -1;
        held[d]     = 0;
        last_own[d] = 3;
        exp_m[d]    = 1'b0;
      end else if (owner[d] >= 0) begin
        vol = (req[owner[d]] == 1'b0);
        frc = (hold_lim[d] != 0) && (held[d] + 1 == hold_lim[d]);
        if (vol || frc) begin
          exp_m[d] = frc && !vol;
          owner[d] = -1;
          held[d]  = 0;
        end else begin
          exp_m[d] = 1'b0;
          held[d]  = held[d] + 1;
        end
      end else begin
        exp_m[d] = 1'b0;
        if (en && req != 4'b0000) begin
          for (int k = 1; k <= 4; k++) begin
            if (owner[d] < 0 && req[(last_own[d] + k) % 4]) begin
              owner[d] = (last_own[d] + k) % 4;
            end
          end
          last_own[d] = owner[d];
          held[d]     = 0;
        end
      end
    end
    if (rst) model_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      for (int d = 0; d < 2; d++) begin
        logic [3:0] e_gnt;
        logic [1:0] e_idx;
        logic [3:0] a_gnt;
        logic [1:0] a_idx;
        logic       a_vld, a_exp;
        e_gnt = 4'b0000;
        e_idx = 2'd0;
        if (owner[d] >= 0) begin
          e_gnt[owner[d]] = 1'b1;
          e_idx = 2'(owner[d]);
        end
        a_gnt = (d == 0) ? gnt_a : gnt_b;
        a_idx = (d == 0) ? idx_a : idx_b;
        a_vld = (d == 0) ? vld_a : vld_b;
        a_exp = (d == 0) ? exp_a : exp_b;
        chk($sformatf("model_gnt%0d", d), 32'(a_gnt), 32'(e_gnt));
        chk($sformatf("model_idx%0d", d), 32'(a_idx), 32'(e_idx));
        chk($sformatf("model_vld%0d", d), 32'(a_vld), 32'(owner[d] >= 0));
        chk($sformatf("model_exp%0d", d), 32'(a_exp), 32'(exp_m[d]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [3:0] seq [5];
  int         nseq;
  int         nexp;
  logic [3:0] prev_g;

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    req = 4'b1111;

    // Reset held for two edges with all requests high.
    tick(1);
    chk("rst_gnt_c1", 32'(gnt_a), 32'h0);
    chk("rst_exp_c1", 32'(exp_a), 32'h0);
    tick(1);
    chk("rst_gnt_c2", 32'(gnt_a), 32'h0);
    rst = 1'b0;

    // Round robin with hold limit 3 on instance a.
    nseq   = 0;
    nexp   = 0;
    prev_g = 4'b0000;
    for (int i = 0; i < 19; i++) begin
      tick(1);
      if (i == 0) begin
        chk("first_gnt", 32'(gnt_a), 32'h1);
        chk("first_idx", 32'(idx_a), 32'h0);
      end
      if (gnt_a != 4'b0000 && prev_g == 4'b0000 && nseq < 5) begin
        seq[nseq] = gnt_a;
        nseq++;
      end
      if (exp_a) nexp++;
      prev_g = gnt_a;
    end
    chk("rr_count", 32'(nseq), 32'd5);
    chk("rr_seq0", 32'(seq[0]), 32'h1);
    chk("rr_seq1", 32'(seq[1]), 32'h2);
    chk("rr_seq2", 32'(seq[2]), 32'h4);
    chk("rr_seq3", 32'(seq[3]), 32'h8);
    chk("rr_seq4", 32'(seq[4]), 32'h1);
    chk("rr_expired", 32'(nexp), 32'd4);
    req = 4'b0000;
    tick(3);

    // Voluntary release after two cycles.
    req = 4'b0100;
    tick(1);
    chk("vol_c1", 32'(gnt_a), 32'h4);
    tick(1);
    chk("vol_c2", 32'(gnt_a), 32'h4);
    req = 4'b0000;
    tick(1);
    chk("vol_rel_gnt", 32'(gnt_a), 32'h0);
    chk("vol_rel_exp", 32'(exp_a), 32'h0);
    tick(2);

    // Instance b (limit 4): owner drops on its fourth cycle.
    req = 4'b0010;
    tick(4);
    chk("lim_c4_gnt", 32'(gnt_b), 32'h2);
    req = 4'b0000;
    tick(1);
    chk("lim_rel_gnt", 32'(gnt_b), 32'h0);
    chk("lim_rel_exp", 32'(exp_b), 32'h0);
    tick(2);

    // en gating.
    en  = 1'b0;
    req = 4'b0010;
    tick(3);
    chk("en_off_gnt", 32'(gnt_a), 32'h0);
    en = 1'b1;
    tick(1);
    chk("en_on_gnt", 32'(gnt_a), 32'h2);
    en = 1'b0;
    tick(1);
    chk("en_drop_c2", 32'(gnt_a), 32'h2);
    tick(1);
    chk("en_drop_c3", 32'(gnt_a), 32'h2);
    req = 4'b0000;
    tick(1);
    chk("en_rel_gnt", 32'(gnt_a), 32'h0);
    chk("en_rel_exp", 32'(exp_a), 32'h0);
    en = 1'b1;
    tick(2);

    // Reset during a grant, then pointer restart.
    req = 4'b1000;
    tick(1);
    chk("mid_gnt", 32'(gnt_a), 32'h8);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_gnt", 32'(gnt_a), 32'h0);
    chk("mid_rst_exp", 32'(exp_a), 32'h0);
    rst = 1'b0;
    req = 4'b1001;
    tick(1);
    chk("post_rst_a", 32'(gnt_a), 32'h1);
    chk("post_rst_b", 32'(gnt_b), 32'h1);

    // Randomized traffic, model-checked every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      tick(1);
    end
    rst = 1'b0;
    tick(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
